// File: rtl/smg_pkg.sv
// smg_pkg: segment patterns, FSM state codes and select check shared by the display path
package smg_pkg;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [1:0] WAIT_SEL = 2'd0;
   localparam logic [1:0] SETTLE   = 2'd1;
   localparam logic [1:0] HOLD     = 2'd2;
   function automatic logic one_hot_low(input logic [7:0] sel);
      return $onehot(~sel);
   endfunction
endpackage

// File: rtl/smg_decode_module_pattern_decode.sv
// smg_pattern_decode: maps a 7-bit active-low segment pattern to a BCD code plus recognised flag
module smg_pattern_decode
   import smg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] code,
   output logic       known
);
   always_comb begin
      code  = BLANK_CODE;
      known = 1'b1;
      case (pattern)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_BLANK: code = BLANK_CODE;
         default:   known = 1'b0;
      endcase
   end
endmodule

// File: rtl/smg_decode_module.sv
// smg_decode_module: rebuilds BCD frames from a scanned 7-segment bus; SMG_DECODE_DP_EN adds per-digit DP capture
module smg_decode_module
   import smg_pkg::*;
#(
   parameter int DIGITS        = 6,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [7:0]            SMG_Data,
   input  logic [DIGITS-1:0]     Scan_Sig,
   output logic [4*DIGITS-1:0]   Number_Data,
   output logic                  Frame_Valid,
   output logic                  Frame_Error
`ifdef SMG_DECODE_DP_EN
   ,
   output logic [DIGITS-1:0]     DP_Data
`endif
);
   logic [1:0]          state;
   logic [DIGITS-1:0]   sel_q, seen;
   logic [7:0]          seg_q, cnt, sel_pad;
   logic [4*DIGITS-1:0] shadow;
   logic [3:0]          code;
   logic                err, known, changed, cap, sel_ok, frame_done;
   always_comb begin
      sel_pad = '1;
      sel_pad[DIGITS-1:0] = Scan_Sig;
   end
   assign sel_ok     = one_hot_low(sel_pad);
   assign changed    = (Scan_Sig != sel_q) || (SMG_Data != seg_q);
   // counter starts at 1 on entry, so >= also covers STABLE_CYCLES == 1
   assign cap        = (state == SETTLE) && !changed && (cnt >= 8'(STABLE_CYCLES - 1));
   assign frame_done = &seen;
   smg_pattern_decode u_dec (
      .pattern(seg_q[6:0]),
      .code   (code),
      .known  (known)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= WAIT_SEL;
         sel_q       <= '1;
         seg_q       <= '1;
         cnt         <= '0;
         seen        <= '0;
         err         <= 1'b0;
         shadow      <= '1;
         Number_Data <= '1;
         Frame_Valid <= 1'b0;
         Frame_Error <= 1'b0;
      end else begin
         Frame_Valid <= frame_done;
         if (state == SETTLE && !changed) begin
            if (cap) state <= HOLD;
            else cnt <= cnt + 8'd1;
         end else if (state == WAIT_SEL || changed) begin
            if (sel_ok) begin
               sel_q <= Scan_Sig;
               seg_q <= SMG_Data;
               cnt   <= 8'd1;
               state <= SETTLE;
            end else begin
               state <= WAIT_SEL;
            end
         end
         if (frame_done) begin
            Number_Data <= shadow;
            Frame_Error <= err;
         end
         seen <= (frame_done ? '0 : seen) | (cap ? ~sel_q : '0);
         err  <= (frame_done ? 1'b0 : err) | (cap & ~known);
         for (int i = 0; i < DIGITS; i++)
            if (cap && !sel_q[i]) shadow[4*i +: 4] <= code;
      end
   end
`ifdef SMG_DECODE_DP_EN
   logic [DIGITS-1:0] dp_shadow;
   always_ff @(posedge CLK) begin
      if (RST) begin
         dp_shadow <= '0;
         DP_Data   <= '0;
      end else begin
         if (frame_done) DP_Data <= dp_shadow;
         for (int i = 0; i < DIGITS; i++)
            if (cap && !sel_q[i]) dp_shadow[i] <= ~seg_q[7];
      end
   end
`endif
endmodule

// File: tb/tb_smg_decode_module.sv
// tb_smg_decode_module: scoreboard bench for the segment-bus decoder (define SMG_DECODE_DP_EN to cover DP_Data)
module tb_smg_decode_module;
   localparam int DIGITS = 6;
   localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   typedef struct packed {
      logic [23:0] num;
      logic        err;
      logic [5:0]  dp;
   } frame_t;
   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  SMG_Data;
   logic [5:0]  Scan_Sig;
   logic [23:0] Number_Data;
   logic        Frame_Valid, Frame_Error;
`ifdef SMG_DECODE_DP_EN
   logic [5:0]  DP_Data;
`endif
   frame_t exp_q[$];
   frame_t mon_e;
   int errors = 0;
   int checks = 0;
   always #5 CLK = ~CLK;
   smg_decode_module #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .SMG_Data   (SMG_Data),
      .Scan_Sig   (Scan_Sig),
      .Number_Data(Number_Data),
      .Frame_Valid(Frame_Valid),
      .Frame_Error(Frame_Error)
`ifdef SMG_DECODE_DP_EN
      ,
      .DP_Data    (DP_Data)
`endif
   );
   always @(negedge CLK) begin
      if (!RST && Frame_Valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got Number_Data=%h Frame_Error=%b, no frame expected", Number_Data, Frame_Error);
         end else begin
            mon_e = exp_q.pop_front();
            checks += 2;
            if (Number_Data !== mon_e.num) begin
               errors++;
               $display("FAIL frame_number: got %h required %h", Number_Data, mon_e.num);
            end
            if (Frame_Error !== mon_e.err) begin
               errors++;
               $display("FAIL frame_error: got %b required %b", Frame_Error, mon_e.err);
            end
`ifdef SMG_DECODE_DP_EN
            checks++;
            if (DP_Data !== mon_e.dp) begin
               errors++;
               $display("FAIL frame_dp: got %b required %b", DP_Data, mon_e.dp);
            end
`endif
         end
      end
   end
   task automatic push(input logic [23:0] n, input logic e, input logic [5:0] dp);
      frame_t f;
      f.num = n;
      f.err = e;
      f.dp  = dp;
      exp_q.push_back(f);
   endtask
   task automatic idle(input int n);
      Scan_Sig = '1;
      SMG_Data = '1;
      repeat (n) @(posedge CLK);
      #1;
   endtask
   task automatic show(input int d, input logic [7:0] seg, input int n);
      Scan_Sig = ~(6'(1) << d);
      SMG_Data = seg;
      repeat (n) @(posedge CLK);
      #1;
   endtask
   task automatic scan(input logic [23:0] digits);
      for (int i = 0; i < DIGITS; i++) show(i, SEG[digits[4*i +: 4]], 10);
   endtask
   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge CLK);
         t++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d pending frames required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask
   task automatic check_reset_outputs(input string name);
      checks += 3;
      if (Number_Data !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL %s_number: got %h required ffffff", name, Number_Data);
      end
      if (Frame_Valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_valid: got %b required 0", name, Frame_Valid);
      end
      if (Frame_Error !== 1'b0) begin
         errors++;
         $display("FAIL %s_error: got %b required 0", name, Frame_Error);
      end
   endtask
   task automatic test_reset();
      RST = 1'b1;
      Scan_Sig = '1;
      SMG_Data = '1;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      check_reset_outputs("reset");
   endtask
   task automatic test_basic();
      push(24'h543210, 1'b0, 6'b0);
      scan(24'h543210);
      idle(5);
      drain("basic");
      idle(20);
      checks++;
      if (Number_Data !== 24'h543210) begin
         errors++;
         $display("FAIL hold_between_frames: got %h required 543210", Number_Data);
      end
   endtask
   task automatic test_glitch();
      push(24'h543310, 1'b0, 6'b0);
      show(0, SEG[0], 10);
      show(1, SEG[1], 10);
      show(2, 8'hA4, 3);
      show(2, 8'hB0, 10);
      for (int i = 3; i < DIGITS; i++) show(i, SEG[i], 10);
      idle(5);
      drain("glitch");
   endtask
   task automatic test_blank_err();
      push(24'h5F3210, 1'b0, 6'b0);
      for (int i = 0; i < 4; i++) show(i, SEG[i], 10);
      show(4, 8'hFF, 10);
      show(5, SEG[5], 10);
      idle(5);
      drain("blank");
      push(24'h5F3210, 1'b1, 6'b0);
      for (int i = 0; i < 4; i++) show(i, SEG[i], 10);
      show(4, 8'h8C, 10);
      show(5, SEG[5], 10);
      idle(5);
      drain("unknown");
      push(24'h543210, 1'b0, 6'b0);
      scan(24'h543210);
      idle(5);
      drain("clean_after_error");
   endtask
   task automatic test_two_low();
      push(24'h456789, 1'b0, 6'b0);
      show(0, SEG[9], 10);
      show(1, SEG[8], 10);
      show(2, SEG[7], 10);
      Scan_Sig = 6'b111100;
      SMG_Data = SEG[8];
      repeat (20) @(posedge CLK);
      #1;
      checks++;
      if (exp_q.size() != 1) begin
         errors++;
         $display("FAIL two_low_no_frame: got %0d pending required 1", exp_q.size());
      end
      show(3, SEG[6], 10);
      show(4, SEG[5], 10);
      show(5, SEG[4], 10);
      idle(5);
      drain("two_low");
   endtask
   task automatic test_rst_mid();
      for (int i = 0; i < 3; i++) show(i, SEG[9], 10);
      RST = 1'b1;
      Scan_Sig = '1;
      SMG_Data = '1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      check_reset_outputs("mid_reset");
      push(24'h777210, 1'b0, 6'b0);
      for (int i = 3; i < DIGITS; i++) show(i, SEG[7], 10);
      for (int i = 0; i < 3; i++) show(i, SEG[i], 10);
      idle(5);
      drain("rst_mid");
   endtask
   task automatic test_back_to_back();
      push(24'h123456, 1'b0, 6'b0);
      push(24'h987654, 1'b0, 6'b0);
      scan(24'h123456);
      scan(24'h987654);
      idle(5);
      drain("back_to_back");
   endtask
`ifdef SMG_DECODE_DP_EN
   task automatic test_dp();
      push(24'h543210, 1'b0, 6'b000010);
      show(0, SEG[0], 10);
      show(1, 8'h79, 10);
      for (int i = 2; i < DIGITS; i++) show(i, SEG[i], 10);
      idle(5);
      drain("dp");
   endtask
`endif
   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_blank_err();
      test_two_low();
      test_rst_mid();
      test_back_to_back();
`ifdef SMG_DECODE_DP_EN
      test_dp();
`endif
      idle(10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
